// File: rtl/picosoc_busfabric.sv
// rtl/picosoc_busfabric.sv - PicoRV32 native-bus fabric: wait-stated RAM, decoded slave ports, error logging
module picosoc_busfabric #(
    parameter int                    MEM_WORDS = 256,
    parameter int                    RAM_WAIT  = 0,
    parameter int                    NUM_SLV   = 4,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE  = {32'h0300_0000, 32'h0200_0008, 32'h0200_0004, 32'h0200_0000},
    parameter logic [32*NUM_SLV-1:0] SLV_MASK  = {32'hFF00_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    parameter int                    TIMEOUT   = 255,
    parameter logic [31:0]           ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_wstrb,
    output logic                   mem_ready,
    output logic [31:0]            mem_rdata,
    output logic [NUM_SLV-1:0]     slv_valid,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    output logic [3:0]             slv_wstrb,
    input  logic [NUM_SLV-1:0]     slv_ready,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_count
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          SW        = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RAM, SLV, RESP} state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 mem_ready_q, mem_ready_d;
    logic [31:0]          mem_rdata_q, mem_rdata_d;
    logic [NUM_SLV-1:0]   slv_valid_q, slv_valid_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [3:0]           wait_q, wait_d;
    logic [15:0]          tmo_q, tmo_d;
    logic                 err_irq_q, err_irq_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [31:0]          ram [0:MEM_WORDS-1];
    logic [31:0]          ram_rd_q;
    logic [AW-1:0]        ram_idx;
    logic                 is_ram, slv_hit, ram_start, log_err;
    logic [SW-1:0]        slv_idx;
    logic [31:0]          err_src;

    assign ram_idx   = mem_addr[AW+1:2];
    assign is_ram    = {1'b0, mem_addr} < RAM_BYTES;
    assign ram_start = resetn && (state_q == IDLE) && mem_valid && is_ram;

    // Downward scan so the lowest matching slave index wins.
    always_comb begin
        slv_hit = 1'b0;
        slv_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                slv_hit = 1'b1;
                slv_idx = SW'(i);
            end
        end
    end

    // Read-before-write: a write access returns the old word.
    always_ff @(posedge clk) begin
        if (ram_start) begin
            ram_rd_q <= ram[ram_idx];
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) ram[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        slv_valid_d = slv_valid_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        tmo_d       = tmo_q;
        err_irq_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;
        log_err     = 1'b0;
        err_src     = addr_q;
        case (state_q)
            IDLE: if (mem_valid) begin
                addr_d  = mem_addr;
                wdata_d = mem_wdata;
                wstrb_d = mem_wstrb;
                if (is_ram) begin
                    state_d = RAM;
                    wait_d  = 4'(RAM_WAIT);
                end else if (slv_hit) begin
                    state_d              = SLV;
                    sel_d                = slv_idx;
                    slv_valid_d          = '0;
                    slv_valid_d[slv_idx] = 1'b1;
                    tmo_d                = '0;
                end else begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ERR_DATA;
                    log_err     = 1'b1;
                    err_src     = mem_addr;
                end
            end
            RAM: begin
                if (wait_q == 4'd0) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ram_rd_q;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            SLV: begin
                if (slv_ready[sel_q]) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = slv_rdata[32*sel_q +: 32];
                    slv_valid_d = '0;
                end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ERR_DATA;
                    slv_valid_d = '0;
                    log_err     = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (log_err) begin
            err_irq_d  = 1'b1;
            err_addr_d = err_src;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            slv_valid_q <= '0;
            sel_q       <= '0;
            wait_q      <= '0;
            tmo_q       <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            slv_valid_q <= slv_valid_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign slv_valid = slv_valid_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_wstrb = wstrb_q;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_picosoc_busfabric.sv
// tb/tb_picosoc_busfabric.sv - directed bench for picosoc_busfabric
// Two instances share stimulus: a = no RAM wait, TIMEOUT 8; b = RAM_WAIT 3, TIMEOUT 16.
module tb_picosoc_busfabric;
    logic         clk = 1'b0;
    logic         resetn;
    logic         mem_valid;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [3:0]   slv_ready;
    logic [127:0] slv_rdata;
    logic         ready_a, ready_b, irq_a, irq_b;
    logic [31:0]  rdata_a, rdata_b, saddr_a, saddr_b, swdata_a, swdata_b, eaddr_a, eaddr_b;
    logic [3:0]   sv_a, sv_b, swstrb_a, swstrb_b;
    logic [7:0]   ecnt_a, ecnt_b;

    int checks = 0;
    int errors = 0;

    int          lat_a, lat_b, vcnt_a;
    logic [31:0] rd_a, rd_b, snap_addr, snap_wdata;
    logic        ir_a, ir_b;
    logic [3:0]  snap_sv, snap_wstrb;

    always #5 clk = ~clk;

    picosoc_busfabric #(.RAM_WAIT(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_a), .mem_rdata(rdata_a),
        .slv_valid(sv_a), .slv_addr(saddr_a), .slv_wdata(swdata_a), .slv_wstrb(swstrb_a),
        .slv_ready(slv_ready), .slv_rdata(slv_rdata), .err_irq(irq_a), .err_addr(eaddr_a),
        .err_count(ecnt_a));

    picosoc_busfabric #(.RAM_WAIT(3), .TIMEOUT(16)) dut_b (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_b), .mem_rdata(rdata_b),
        .slv_valid(sv_b), .slv_addr(saddr_b), .slv_wdata(swdata_b), .slv_wstrb(swstrb_b),
        .slv_ready(slv_ready), .slv_rdata(slv_rdata), .err_irq(irq_b), .err_addr(eaddr_b),
        .err_count(ecnt_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on both instances; mem_valid drops after the decode edge.
    // sdly > 0: slave ssel asserts ready in its sdly-th valid cycle; 0 = never.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int sdly, input int ssel);
        logic done_a = 1'b0;
        logic done_b = 1'b0;
        lat_a = -1; lat_b = -1; vcnt_a = 0;
        rd_a = 'x; rd_b = 'x; ir_a = 1'bx; ir_b = 1'bx;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        for (int cyc = 1; cyc <= 40 && !(done_a && done_b); cyc++) begin
            @(negedge clk);
            mem_valid = 1'b0;
            slv_ready = (sdly > 0 && cyc == sdly) ? (4'b0001 << ssel) : 4'b0000;
            if (cyc == 1) begin
                snap_sv = sv_a; snap_addr = saddr_a; snap_wdata = swdata_a; snap_wstrb = swstrb_a;
            end
            if (sv_a == (4'b0001 << ssel)) vcnt_a++;
            if (!done_a && ready_a) begin
                done_a = 1'b1; lat_a = cyc; rd_a = rdata_a; ir_a = irq_a;
            end
            if (!done_b && ready_b) begin
                done_b = 1'b1; lat_b = cyc; rd_b = rdata_b; ir_b = irq_b;
            end
        end
        slv_ready = 4'b0000;
    endtask

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        slv_ready = '0; slv_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'b0, ready_a, ready_b}, 32'h0);
        check("rst_rdata", rdata_a | rdata_b, 32'h0);
        check("rst_sv", {24'b0, sv_a, sv_b}, 32'h0);
        check("rst_errs", {ecnt_a, ecnt_b, 14'b0, irq_a, irq_b}, 32'h0);
        check("rst_eaddr", eaddr_a | eaddr_b, 32'h0);
        resetn = 1'b1;

        access(32'h10, 32'h1234_5678, 4'hF, 0, 0);
        check("wr_lat_a", lat_a, 2);
        check("wr_lat_b", lat_b, 5);
        access(32'h10, 32'h0, 4'h0, 0, 0);
        check("rd_lat_a", lat_a, 2);
        check("rd_lat_b", lat_b, 5);
        check("rd_data_a", rd_a, 32'h1234_5678);
        check("rd_data_b", rd_b, 32'h1234_5678);

        access(32'h20, 32'h1122_3344, 4'hF, 0, 0);
        access(32'h20, 32'h0000_AB00, 4'b0010, 0, 0);
        check("wr_old_b", rd_b, 32'h1122_3344);
        access(32'h20, 32'h0, 4'h0, 0, 0);
        check("strb_a", rd_a, 32'h1122_AB44);
        check("strb_b", rd_b, 32'h1122_AB44);
        check("strb_lat_b", lat_b, 5);

        access(32'h3FC, 32'hA5A5_0FF0, 4'hF, 0, 0);
        access(32'h3FC, 32'h0, 4'h0, 0, 0);
        check("top_word", rd_a, 32'hA5A5_0FF0);

        access(32'h0400_0000, 32'h0, 4'h0, 0, 0);
        check("unm_lat", lat_a, 1);
        check("unm_data", rd_a, 32'hDEAD_BEEF);
        check("unm_irq", {31'b0, ir_a}, 32'h1);
        @(negedge clk);
        check("unm_eaddr", eaddr_a, 32'h0400_0000);
        check("unm_cnt", ecnt_a, 32'd1);
        check("irq_pulse", {30'b0, irq_a, irq_b}, 32'h0);

        access(32'h400, 32'h0, 4'h0, 0, 0);
        check("ramend_data", rd_b, 32'hDEAD_BEEF);
        check("ramend_lat_b", lat_b, 1);
        check("ramend_eaddr", eaddr_b, 32'h400);

        slv_rdata[96 +: 32] = 32'hCAFE_0001;
        access(32'h0300_0040, 32'h0, 4'h0, 5, 3);
        check("s3_sv", snap_sv, 32'b1000);
        check("s3_vcnt", vcnt_a, 5);
        check("s3_lat", lat_a, 6);
        check("s3_data", rd_a, 32'hCAFE_0001);
        check("s3_irq", {31'b0, ir_a}, 32'h0);

        slv_rdata[64 +: 32] = 32'h5151_2222;
        access(32'h0200_0008, 32'h0, 4'h0, 1, 2);
        check("s2_sv", snap_sv, 32'b0100);
        check("s2_lat", lat_a, 2);
        check("s2_data", rd_b, 32'h5151_2222);

        access(32'h0200_0004, 32'h7766_5544, 4'b0011, 2, 1);
        check("s1_sv", snap_sv, 32'b0010);
        check("s1_addr", snap_addr, 32'h0200_0004);
        check("s1_wdata", snap_wdata, 32'h7766_5544);
        check("s1_wstrb", snap_wstrb, 32'b0011);

        slv_rdata[0 +: 32] = 32'h0000_0808;
        access(32'h0200_0000, 32'h0, 4'h0, 8, 0);
        check("edge_lat", lat_a, 9);
        check("edge_data", rd_a, 32'h0000_0808);
        check("edge_irq", {31'b0, ir_a}, 32'h0);

        access(32'h0200_0000, 32'h0, 4'h0, 0, 0);
        check("tmo_vcnt", vcnt_a, 8);
        check("tmo_lat_a", lat_a, 9);
        check("tmo_lat_b", lat_b, 17);
        check("tmo_data", rd_a, 32'hDEAD_BEEF);
        check("tmo_irq", {30'b0, ir_a, ir_b}, 32'h3);
        check("tmo_eaddr", eaddr_a, 32'h0200_0000);
        check("tmo_cnt", ecnt_a, 32'd3);

        for (int i = 0; i < 252; i++) access(32'h0200_0000, 32'h0, 4'h0, 0, 0);
        check("cnt_255", ecnt_a, 32'd255);
        for (int i = 0; i < 8; i++) access(32'h0200_0000, 32'h0, 4'h0, 0, 0);
        check("sat_a", ecnt_a, 32'd255);
        check("sat_b", ecnt_b, 32'd255);

        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0300_0000; mem_wstrb = 4'h0;
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_sv", sv_a, 32'b1000);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mid_rst_sv", {24'b0, sv_a, sv_b}, 32'h0);
        check("mid_rst_ready", {30'b0, ready_a, ready_b}, 32'h0);
        check("mid_rst_cnt", {16'b0, ecnt_a, ecnt_b}, 32'h0);
        access(32'h10, 32'h0, 4'h0, 0, 0);
        check("post_rst_a", rd_a, 32'h1234_5678);
        check("post_rst_b", rd_b, 32'h1234_5678);
        check("post_rst_lat", lat_a, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
